// File: rtl/accumulator_pkg.sv
// Shared definitions for the accumulator control unit: command encodings
// and the controller state enum.
package accumulator_pkg;

  localparam int ACC_W = 4;

  // Command field encodings as seen on the cmd input
  typedef enum logic [1:0] {
    CMD_ADD = 2'b00,
    CMD_SUB = 2'b01,
    CMD_LDA = 2'b10,
    CMD_RDA = 2'b11
  } cmd_t;

  // Controller states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    LOAD  = 3'd3,
    DRIVE = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/accumulator_unit.sv
// Accumulator controller: sequences ADD/SUB through an external ALU that
// shares a 4-bit tri-state bus, loads the accumulator from the bus, and
// drives the accumulator back onto the bus on request.
module accumulator_unit
  import accumulator_pkg::*;
#(
  parameter int DATA_W = ACC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd,
  output logic              cmd_ready,
  output logic              done,
  inout  wire  [DATA_W-1:0] data_bus,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              ALU_operation,
  output logic              ALU_enable,
  input  logic              carry_in,
  output logic              carry_flag
);

  state_t              state;
  state_t              next_state;
  logic [DATA_W-1:0]   acc_q;
  logic [DATA_W-1:0]   tmp_q;
  logic                carry_q;
  logic                op_q;
  logic                accept;
  cmd_t                cmd_in;

  assign cmd_in = cmd_t'(cmd);
  assign accept = cmd_valid && (state == IDLE);

  // State register; reset wins over any command presented on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_in)
            CMD_ADD, CMD_SUB: next_state = FETCH;
            CMD_LDA:          next_state = LOAD;
            CMD_RDA:          next_state = DRIVE;
            default:          next_state = IDLE;
          endcase
        end
      end
      FETCH:   next_state = EXEC;
      EXEC:    next_state = DONE;
      LOAD:    next_state = DONE;
      DRIVE:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers: operation latch, temp, accumulator and carry.
  // Captures happen on the edge that leaves the capturing state.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      tmp_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && (cmd_in == CMD_ADD || cmd_in == CMD_SUB)) begin
            op_q <= (cmd_in == CMD_SUB);
          end
        end
        FETCH: tmp_q <= data_bus;
        EXEC: begin
          acc_q   <= data_bus;
          carry_q <= carry_in;
        end
        LOAD:    acc_q <= data_bus;
        default: ;
      endcase
    end
  end

  assign cmd_ready     = (state == IDLE);
  assign done          = (state == DONE);
  assign ALU_enable    = (state == EXEC);
  assign ALU_operation = op_q && (state == FETCH || state == EXEC);
  assign A             = acc_q;
  assign B             = tmp_q;
  assign carry_flag    = carry_q;

  // The unit only ever drives the bus in DRIVE, which excludes EXEC where the ALU owns it
  assign data_bus = (state == DRIVE) ? acc_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_accumulator_unit.sv
// Bench for accumulator_unit: a behavioural ALU and external bus source sit
// on the shared bus; directed table vectors, hand-written corner sequences
// and random commands are checked against a plain-arithmetic model.
module tb_accumulator_unit;
  import accumulator_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic       done;
  tri   [3:0] data_bus;
  logic [3:0] A;
  logic [3:0] B;
  logic       ALU_operation;
  logic       ALU_enable;
  logic       carry_in;
  logic       carry_flag;

  logic       ext_en;
  logic [3:0] ext_val;
  logic [4:0] alu_res;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [3:0] m_acc;
  logic [3:0] m_tmp;
  logic       m_c;

  always #5 clk = ~clk;

  accumulator_unit dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd          (cmd),
    .cmd_ready    (cmd_ready),
    .done         (done),
    .data_bus     (data_bus),
    .A            (A),
    .B            (B),
    .ALU_operation(ALU_operation),
    .ALU_enable   (ALU_enable),
    .carry_in     (carry_in),
    .carry_flag   (carry_flag)
  );

  // Behavioural ALU: two's-complement add/subtract with carry out
  always_comb begin
    if (ALU_operation) alu_res = {1'b0, A} + {1'b0, ~B} + 5'd1;
    else               alu_res = {1'b0, A} + {1'b0, B};
  end
  assign carry_in = alu_res[4];
  assign data_bus = ext_en ? ext_val : (ALU_enable ? alu_res[3:0] : 4'bzzzz);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive 0 from the bench and confirm nothing else is on the bus
  task automatic probe_release(input string nm);
    ext_val = 4'h0;
    ext_en  = 1'b1;
    #1;
    check(nm, {28'd0, data_bus}, 32'd0);
    ext_en  = 1'b0;
  endtask

  // Issue one command from IDLE, supply v on the bus in FETCH/LOAD, and
  // check latency, results, bus behaviour and return to IDLE.
  task automatic run_cmd(input logic [1:0] c, input logic [3:0] v,
                         input logic [3:0] exp_a, input logic [3:0] exp_b,
                         input logic exp_c, input string nm);
    int lat;
    int exp_lat;
    exp_lat = (c == CMD_ADD || c == CMD_SUB) ? 3 : 2;
    cmd_valid = 1'b1;
    cmd       = c;
    step();
    cmd_valid = 1'b0;
    lat = 1;
    if (c != CMD_RDA) begin
      ext_val = v;
      ext_en  = 1'b1;
    end else begin
      check({nm, " rda_bus"}, {28'd0, data_bus}, {28'd0, exp_a});
      check({nm, " rda_alu_en"}, {31'd0, ALU_enable}, 32'd0);
    end
    while (!done && lat < 8) begin
      step();
      ext_en = 1'b0;
      lat++;
    end
    check({nm, " latency"}, lat, exp_lat);
    check({nm, " A"}, {28'd0, A}, {28'd0, exp_a});
    check({nm, " B"}, {28'd0, B}, {28'd0, exp_b});
    check({nm, " carry"}, {31'd0, carry_flag}, {31'd0, exp_c});
    if (c == CMD_RDA) probe_release({nm, " bus_release"});
    step();
    check({nm, " done_width"}, {31'd0, done}, 32'd0);
    check({nm, " ready"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  // Apply one command to the model at the level of the command's meaning
  task automatic model_apply(input logic [1:0] c, input logic [3:0] v);
    int s;
    case (c)
      CMD_ADD: begin
        m_tmp = v;
        s     = int'(m_acc) + int'(v);
        m_c   = (s > 15);
        m_acc = 4'(s % 16);
      end
      CMD_SUB: begin
        m_tmp = v;
        m_c   = (m_acc >= v);
        s     = (int'(m_acc) - int'(v) + 16) % 16;
        m_acc = 4'(s);
      end
      CMD_LDA: m_acc = v;
      default: ;
    endcase
  endtask

  typedef struct {
    logic [3:0] a0;
    logic [1:0] op;
    logic [3:0] b;
    logic [3:0] exp_a;
    logic       exp_c;
  } vec_t;

  vec_t vecs[6];

  typedef struct {
    logic r;
    logic d;
    logic en;
    logic ext;
  } cyc_t;

  cyc_t hold_tab[8];

  initial begin
    vecs[0] = '{a0: 4'h9, op: CMD_ADD, b: 4'h8, exp_a: 4'h1, exp_c: 1'b1};
    vecs[1] = '{a0: 4'h5, op: CMD_SUB, b: 4'h3, exp_a: 4'h2, exp_c: 1'b1};
    vecs[2] = '{a0: 4'h3, op: CMD_SUB, b: 4'h5, exp_a: 4'hE, exp_c: 1'b0};
    vecs[3] = '{a0: 4'hF, op: CMD_ADD, b: 4'h1, exp_a: 4'h0, exp_c: 1'b1};
    vecs[4] = '{a0: 4'h7, op: CMD_SUB, b: 4'h7, exp_a: 4'h0, exp_c: 1'b1};
    vecs[5] = '{a0: 4'h2, op: CMD_ADD, b: 4'h3, exp_a: 4'h5, exp_c: 1'b0};

    // ready, done, ALU_enable, bench drives bus -- per cycle after each edge
    hold_tab[0] = '{r: 1'b0, d: 1'b0, en: 1'b0, ext: 1'b1};
    hold_tab[1] = '{r: 1'b0, d: 1'b0, en: 1'b1, ext: 1'b0};
    hold_tab[2] = '{r: 1'b0, d: 1'b1, en: 1'b0, ext: 1'b0};
    hold_tab[3] = '{r: 1'b1, d: 1'b0, en: 1'b0, ext: 1'b0};
    hold_tab[4] = '{r: 1'b0, d: 1'b0, en: 1'b0, ext: 1'b1};
    hold_tab[5] = '{r: 1'b0, d: 1'b0, en: 1'b1, ext: 1'b0};
    hold_tab[6] = '{r: 1'b0, d: 1'b1, en: 1'b0, ext: 1'b0};
    hold_tab[7] = '{r: 1'b1, d: 1'b0, en: 1'b0, ext: 1'b0};

    reset = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; ext_en = 1'b0; ext_val = 4'h0;
    m_acc = 4'h0; m_tmp = 4'h0; m_c = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset then idle
    check("rst A", {28'd0, A}, 32'd0);
    check("rst B", {28'd0, B}, 32'd0);
    check("rst carry", {31'd0, carry_flag}, 32'd0);
    check("rst ready", {31'd0, cmd_ready}, 32'd1);
    check("rst alu_en", {31'd0, ALU_enable}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    probe_release("rst bus");

    // Table vectors: load then arithmetic
    for (int i = 0; i < 6; i++) begin
      run_cmd(CMD_LDA, vecs[i].a0, vecs[i].a0, m_tmp, m_c, $sformatf("vec%0d lda", i));
      m_acc = vecs[i].a0;
      run_cmd(vecs[i].op, vecs[i].b, vecs[i].exp_a, vecs[i].b, vecs[i].exp_c,
              $sformatf("vec%0d op", i));
      m_acc = vecs[i].exp_a; m_tmp = vecs[i].b; m_c = vecs[i].exp_c;
    end

    // RDA with A=6
    run_cmd(CMD_LDA, 4'h6, 4'h6, m_tmp, m_c, "rda_setup");
    m_acc = 4'h6;
    run_cmd(CMD_RDA, 4'h0, 4'h6, m_tmp, m_c, "rda6");

    // cmd_valid held high during ADD: two back-to-back ADDs of 1 starting at A=2
    run_cmd(CMD_LDA, 4'h2, 4'h2, m_tmp, m_c, "hold_setup");
    cmd_valid = 1'b1;
    cmd       = CMD_ADD;
    for (int k = 0; k < 8; k++) begin
      step();
      ext_en  = 1'b0;
      if (k == 4) cmd_valid = 1'b0;
      check($sformatf("hold c%0d ready", k), {31'd0, cmd_ready}, {31'd0, hold_tab[k].r});
      check($sformatf("hold c%0d done", k), {31'd0, done}, {31'd0, hold_tab[k].d});
      check($sformatf("hold c%0d alu_en", k), {31'd0, ALU_enable}, {31'd0, hold_tab[k].en});
      if (hold_tab[k].ext) begin
        ext_val = 4'h1;
        ext_en  = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    check("hold A", {28'd0, A}, 32'd4);
    check("hold carry", {31'd0, carry_flag}, 32'd0);

    // Reset asserted in EXEC after a carry was set and A reloaded
    run_cmd(CMD_LDA, 4'hF, 4'hF, 4'h1, 1'b0, "rx lda");
    run_cmd(CMD_ADD, 4'h2, 4'h1, 4'h2, 1'b1, "rx add");
    run_cmd(CMD_LDA, 4'h7, 4'h7, 4'h2, 1'b1, "rx lda_keep");
    cmd_valid = 1'b1; cmd = CMD_ADD;
    step();
    cmd_valid = 1'b0;
    ext_val = 4'h3; ext_en = 1'b1;
    step();
    ext_en = 1'b0;
    check("rx in_exec", {31'd0, ALU_enable}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rx done", {31'd0, done}, 32'd0);
    check("rx A", {28'd0, A}, 32'd0);
    check("rx B", {28'd0, B}, 32'd0);
    check("rx carry", {31'd0, carry_flag}, 32'd0);
    check("rx alu_en", {31'd0, ALU_enable}, 32'd0);
    check("rx ready", {31'd0, cmd_ready}, 32'd1);
    probe_release("rx bus");
    step();
    check("rx done_after", {31'd0, done}, 32'd0);

    // Reset with simultaneous command: command dropped
    reset = 1'b1; cmd_valid = 1'b1; cmd = CMD_LDA;
    step();
    reset = 1'b0; cmd_valid = 1'b0;
    check("rc ready", {31'd0, cmd_ready}, 32'd1);
    step();
    check("rc done", {31'd0, done}, 32'd0);
    check("rc ready2", {31'd0, cmd_ready}, 32'd1);

    // Random commands against the model
    m_acc = 4'h0; m_tmp = 4'h0; m_c = 1'b0;
    for (int i = 0; i < 40; i++) begin
      logic [1:0] rc;
      logic [3:0] rv;
      rc = 2'($urandom_range(0, 3));
      rv = 4'($urandom_range(0, 15));
      model_apply(rc, rv);
      run_cmd(rc, rv, m_acc, m_tmp, m_c, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accumulator_unit.md
ACCUMULATOR_UNIT -- requirements
Module: accumulator_unit

Interface
REQ-001 SHALL have a single clock domain; reset is synchronous and active-high.
REQ-002 SHALL have these ports (name  direction  width  meaning):
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- cmd_valid  input  1  command request
- cmd  input  2  00 ADD, 01 SUB, 10 LDA (load ACC from bus), 11 RDA (drive ACC onto bus)
- cmd_ready  output  1  high in IDLE only
- done  output  1  one-cycle pulse when a command completes
- data_bus  inout  4  shared tri-state 4-bit bus
- A  output  4  accumulator value, to the ALU A operand
- B  output  4  temp register value, to the ALU B operand
- ALU_operation  output  1  0 add, 1 subtract
- ALU_enable  output  1  ALU drives the bus while high
- carry_in  input  1  ALU carry_out
- carry_flag  output  1  latched carry

Function
REQ-003 SHALL accept a command only when cmd_valid=1 and cmd_ready=1 at a rising edge; in every other state cmd_valid SHALL be ignored, with no queueing.
REQ-004 SHALL use the FSM states IDLE, FETCH, EXEC, LOAD, DRIVE and DONE.
REQ-005 SHALL make these state transitions:
- IDLE: ADD/SUB -> FETCH; LDA -> LOAD; RDA -> DRIVE.
- FETCH -> EXEC.
- EXEC, LOAD, DRIVE -> DONE.
- DONE -> IDLE.
REQ-006 SHALL latch the operation type (ADD/SUB) at acceptance and hold ALU_operation constant from FETCH through EXEC; ALU_operation=0 in all other states.
REQ-007 SHALL, in FETCH, capture data_bus (driven by an external source) into B on the exit edge.
REQ-008 SHALL assert ALU_enable=1 only in EXEC, and on the EXEC exit edge SHALL capture data_bus into A and carry_in into carry_flag.
REQ-009 SHALL, in LOAD, capture data_bus into A on the exit edge; carry_flag SHALL remain unchanged.
REQ-010 SHALL drive A onto data_bus only in DRIVE and hold data_bus at 4'bz in every other state.
REQ-011 SHALL never drive data_bus while ALU_enable=1.
REQ-012 SHALL pulse done=1 for exactly one cycle in DONE.
REQ-013 SHALL meet these latencies from the accept edge to the done cycle: ADD/SUB 3 cycles; LDA and RDA 2 cycles.
REQ-014 SHALL store carry_in raw; for SUB, carry_flag=1 means no borrow, and wrap-around is modulo 16 with no saturation.
REQ-015 SHALL treat A and B as combinational views of the ACC and temp registers.

Reset
REQ-016 SHALL, on reset=1 at a clock edge, force:
- state to IDLE;
- A=0, B=0, carry_flag=0;
- the latched operation to 0.
REQ-017 SHALL apply REQ-016 mid-operation as well, with no done pulse, ALU_enable=0 and data_bus=z from the following cycle.
REQ-018 SHALL give reset priority over a simultaneous cmd_valid, which SHALL be dropped.

Structure
REQ-019 SHALL place the command encodings (ADD/SUB/LDA/RDA) and the FSM state enum in a shared package accumulator_pkg.
REQ-020 SHALL be implemented as a single module with no sub-modules; the tri-state driver SHALL be a continuous assignment in accumulator_unit.

Verification
REQ-021 The bench SHALL model the ALU on the bus and cover these directed scenarios:
- Reset then idle: A=0, B=0, carry_flag=0, cmd_ready=1, data_bus=z, ALU_enable=0.
- LDA with bus=9, then ADD with bus=8 in FETCH: A=1, carry_flag=1, done exactly 3 cycles after accept.
- LDA 5, then SUB 3: A=2, carry_flag=1; LDA 3, then SUB 5: A=E, carry_flag=0.
- RDA with A=6: data_bus=6 for exactly one cycle, then z; ALU_enable never high at the same time.
- cmd_valid held high during ADD: exactly one command executes, and the next is accepted only after DONE.
- reset asserted in EXEC: no done pulse, A=0, carry_flag=0, bus released, cmd_ready=1 the next cycle.
